// File: rtl/multi_channel_counter_fsm_if.sv
// Control/status bundle for multi_channel_counter_fsm: per-channel start/abort/pause
// requests and terminal counts in, per-channel state decodes and counters out.
interface multi_channel_counter_fsm_if #(
  parameter int CNT_WIDTH = 7,
  parameter int NUM_CH    = 4
);
  logic [NUM_CH-1:0]           start_i;
  logic [NUM_CH-1:0]           abort_i;
  logic [NUM_CH-1:0]           pause_i;
  logic [NUM_CH-1:0]           mode_i;
  logic [NUM_CH*CNT_WIDTH-1:0] cnt_val_i;
  logic [NUM_CH-1:0]           idle_o;
  logic [NUM_CH-1:0]           run_o;
  logic [NUM_CH-1:0]           done_o;
  logic [NUM_CH*CNT_WIDTH-1:0] cnt_o;
  logic                        done_any_o;

  modport master (
    output start_i, abort_i, pause_i, mode_i, cnt_val_i,
    input  idle_o, run_o, done_o, cnt_o, done_any_o
  );

  modport slave (
    input  start_i, abort_i, pause_i, mode_i, cnt_val_i,
    output idle_o, run_o, done_o, cnt_o, done_any_o
  );
endinterface

// File: rtl/multi_channel_counter_fsm.sv
// NUM_CH independent "run for N cycles, then pulse done" sequencers with
// one-shot/periodic modes, pause and abort.
//
// state | meaning
// IDLE  | waiting for start; counter cleared
// RUN   | counting 0..N-1, held while paused
// DONE  | single-cycle completion pulse; reloads to RUN in periodic mode
module multi_channel_counter_fsm #(
  parameter int CNT_WIDTH = 7,
  parameter int NUM_CH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multi_channel_counter_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_r [NUM_CH];
  logic [CNT_WIDTH-1:0] n_r   [NUM_CH];
  logic [NUM_CH-1:0]    m_r;
  logic [NUM_CH-1:0]    done_v;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!rst_n) begin
        state[k] <= IDLE;
        cnt_r[k] <= '0;
        n_r[k]   <= '0;
        m_r[k]   <= 1'b0;
      end else begin
        unique case (state[k])
          IDLE: begin
            if (bus.start_i[k] && !bus.abort_i[k]) begin
              n_r[k]   <= bus.cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH];
              m_r[k]   <= bus.mode_i[k];
              cnt_r[k] <= '0;
              // A zero terminal count skips RUN entirely.
              state[k] <= (bus.cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH] != '0) ? RUN : DONE;
            end
          end
          RUN: begin
            if (bus.abort_i[k]) begin
              state[k] <= IDLE;
              cnt_r[k] <= '0;
            end else if (!bus.pause_i[k]) begin
              if (cnt_r[k] == n_r[k] - CNT_ONE) state[k] <= DONE;
              else                              cnt_r[k] <= cnt_r[k] + CNT_ONE;
            end
          end
          DONE: begin
            cnt_r[k] <= '0;
            // Periodic reload is suppressed for N=0 so done cannot stick high.
            if (!bus.abort_i[k] && m_r[k] && n_r[k] != '0) state[k] <= RUN;
            else                                           state[k] <= IDLE;
          end
          default: begin
            state[k] <= IDLE;
            cnt_r[k] <= '0;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.idle_o[g]                      = (state[g] == IDLE);
    assign bus.run_o[g]                       = (state[g] == RUN);
    assign done_v[g]                          = (state[g] == DONE);
    assign bus.cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_r[g];
  end

  assign bus.done_o     = done_v;
  assign bus.done_any_o = |done_v;

endmodule
